pluck_detector: RTL and testbench

Per-string beam-break detector between the ADC string-update stage and the SPI link to the Pi. Each 8-bit ADC sample, tagged with its string index, runs through a hysteresis comparator and a consecutive-sample debouncer. The resulting note-on and note-off transitions are queued as events in a small FIFO, which the SPI slave drains through a valid/ready handshake. The Pi therefore receives discrete pluck events rather than polling raw readings.

---
 rtl/pluck_pkg.sv | 29 ++
 rtl/pluck_event_fifo.sv | 74 +++++++
 rtl/pluck_detector.sv | 146 ++++++++++++++
 tb/tb_pluck_detector.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pluck_pkg.sv
// Shared types for the pluck detector: per-string FSM states and the queued event format.
// Defining PLUCK_TIMESTAMP_EN widens each event with a 16-bit coarse timestamp (EVT_W 8 -> 24).
package pluck_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARM_ON,
    ST_ON,
    ST_ARM_OFF
  } str_state_e;

`ifdef PLUCK_TIMESTAMP_EN
  typedef struct packed {
    logic [15:0] ts;
    logic        on;
    logic [3:0]  rsvd;
    logic [2:0]  str;
  } pluck_evt_t;
`else
  typedef struct packed {
    logic        on;
    logic [3:0]  rsvd;
    logic [2:0]  str;
  } pluck_evt_t;
`endif

  localparam int EVT_W = $bits(pluck_evt_t);

endpackage

// File: rtl/pluck_event_fifo.sv
// Event FIFO: circular store feeding a registered head stage, so a pushed event
// becomes visible one cycle after the push. Pushes while full are dropped and latched in overflow.
module pluck_event_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  output logic         full,
  output logic         head_valid,
  output logic [W-1:0] head_data,
  input  logic         head_ready,
  output logic         overflow,
  input  logic         clear_overflow
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   mem_cnt_q, mem_cnt_d;
  logic          head_vld_q, head_vld_d;
  logic [W-1:0]  head_q, head_d;
  logic          ovf_q, ovf_d;
  logic [AW:0]   occ;
  logic          mem_empty, pop, load, wr_en, drop;

  // Occupancy counts the head stage too, so "full" means DEPTH events held in total.
  always_comb begin
    occ        = mem_cnt_q + {{AW{1'b0}}, head_vld_q};
    full       = (occ == (AW+1)'(DEPTH));
    mem_empty  = (mem_cnt_q == '0);
    pop        = head_vld_q && head_ready;
    wr_en      = push && (!full || pop);
    drop       = push && full && !pop;
    load       = !mem_empty && (!head_vld_q || pop);
    wr_ptr_d   = wr_ptr_q + AW'(wr_en);
    rd_ptr_d   = rd_ptr_q + AW'(load);
    mem_cnt_d  = mem_cnt_q + (AW+1)'(wr_en) - (AW+1)'(load);
    head_vld_d = load || (head_vld_q && !pop);
    head_d     = load ? mem_q[rd_ptr_q] : head_q;
    ovf_d      = clear_overflow ? 1'b0 : (ovf_q || drop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      mem_cnt_q  <= '0;
      head_vld_q <= 1'b0;
      head_q     <= '0;
      ovf_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      mem_cnt_q  <= mem_cnt_d;
      head_vld_q <= head_vld_d;
      head_q     <= head_d;
      ovf_q      <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= push_data;
  end

  assign head_valid = head_vld_q;
  assign head_data  = head_q;
  assign overflow   = ovf_q;

endmodule

// File: rtl/pluck_detector.sv
// pluck_detector: per-string hysteresis comparator and debouncer on strobed ADC samples, queuing note-on/off events.
// Define PLUCK_TIMESTAMP_EN to stamp each event with a cycle/256 counter in evt_data[23:8].
module pluck_detector
  import pluck_pkg::*;
#(
  parameter int  NUM_STRINGS = 8,
  parameter int  DEBOUNCE    = 3,
  parameter int  FIFO_DEPTH  = 8,
  localparam int SW          = (NUM_STRINGS > 1) ? $clog2(NUM_STRINGS) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   sample_valid,
  input  logic [SW-1:0]          sample_string,
  input  logic [7:0]             sample_value,
  input  logic [7:0]             thr_on,
  input  logic [7:0]             thr_off,
  output logic                   evt_valid,
  input  logic                   evt_ready,
  output logic [EVT_W-1:0]       evt_data,
  output logic [NUM_STRINGS-1:0] string_on,
  output logic                   overflow,
  input  logic                   clear_overflow
);

  localparam logic [3:0] DEB = 4'(DEBOUNCE);

  str_state_e             state_q [NUM_STRINGS];
  str_state_e             state_d [NUM_STRINGS];
  logic [3:0]             cnt_q   [NUM_STRINGS];
  logic [3:0]             cnt_d   [NUM_STRINGS];
  logic [NUM_STRINGS-1:0] string_on_q, string_on_d;
  logic [7:0]             eff_off;
  logic                   is_blocked, is_clear, hit, push, push_on;
  pluck_evt_t             push_evt;
  logic                   fifo_full;

`ifdef PLUCK_TIMESTAMP_EN
  logic [7:0]  div_q, div_d;
  logic [15:0] ts_q, ts_d;

  always_comb begin
    div_d = div_q + 8'd1;
    ts_d  = (div_q == 8'hFF) ? ts_q + 16'd1 : ts_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_q <= '0;
      ts_q  <= '0;
    end else begin
      div_q <= div_d;
      ts_q  <= ts_d;
    end
  end
`endif

  // Clamping thr_off to thr_on keeps "blocked" and "clear" mutually exclusive.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    push        = 1'b0;
    push_on     = 1'b0;
    eff_off     = (thr_off > thr_on) ? thr_on : thr_off;
    is_blocked  = (sample_value >= thr_on);
    is_clear    = (sample_value < eff_off);
    hit         = sample_valid && (int'(sample_string) < NUM_STRINGS);
    for (int i = 0; i < NUM_STRINGS; i++) begin
      if (hit && int'(sample_string) == i) begin
        case (state_q[i])
          ST_IDLE, ST_ARM_ON: begin
            if (!is_blocked) begin
              state_d[i] = ST_IDLE;
              cnt_d[i]   = '0;
            end else if (cnt_q[i] + 4'd1 == DEB) begin
              state_d[i] = ST_ON;
              cnt_d[i]   = '0;
              push       = 1'b1;
              push_on    = 1'b1;
            end else begin
              state_d[i] = ST_ARM_ON;
              cnt_d[i]   = cnt_q[i] + 4'd1;
            end
          end
          ST_ON, ST_ARM_OFF: begin
            if (!is_clear) begin
              state_d[i] = ST_ON;
              cnt_d[i]   = '0;
            end else if (cnt_q[i] + 4'd1 == DEB) begin
              state_d[i] = ST_IDLE;
              cnt_d[i]   = '0;
              push       = 1'b1;
            end else begin
              state_d[i] = ST_ARM_OFF;
              cnt_d[i]   = cnt_q[i] + 4'd1;
            end
          end
        endcase
      end
    end
    for (int i = 0; i < NUM_STRINGS; i++) begin
      string_on_d[i] = (state_d[i] == ST_ON) || (state_d[i] == ST_ARM_OFF);
    end
    push_evt      = '0;
    push_evt.on   = push_on;
    push_evt.rsvd = '0;
    push_evt.str  = 3'(sample_string);
`ifdef PLUCK_TIMESTAMP_EN
    push_evt.ts   = ts_q;
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_STRINGS; i++) begin
        state_q[i] <= ST_IDLE;
        cnt_q[i]   <= '0;
      end
      string_on_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      string_on_q <= string_on_d;
    end
  end

  // A full FIFO drops the event, but the string state above has still moved.
  pluck_event_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (EVT_W)
  ) u_fifo (
    .clk            (clk),
    .rst_n          (reset),
    .push           (push),
    .push_data      (push_evt),
    .full           (fifo_full),
    .head_valid     (evt_valid),
    .head_data      (evt_data),
    .head_ready     (evt_ready),
    .overflow       (overflow),
    .clear_overflow (clear_overflow)
  );

  assign string_on = string_on_q;

endmodule

// File: tb/tb_pluck_detector.sv
// Testbench for pluck_detector: directed scenarios plus randomized traffic against a queue-based event model.
`timescale 1ns/1ps
module tb_pluck_detector;
  import pluck_pkg::*;

  localparam int DEB   = 3;
  localparam int DEPTH = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             sample_valid;
  logic [2:0]       sample_string;
  logic [7:0]       sample_value;
  logic [7:0]       thr_on, thr_off;
  logic             evt_valid;
  logic             evt_ready;
  logic [EVT_W-1:0] evt_data;
  logic [7:0]       string_on;
  logic             overflow;
  logic             clear_overflow;

  always #5 clk = ~clk;

  pluck_detector #(.NUM_STRINGS(8), .DEBOUNCE(DEB), .FIFO_DEPTH(DEPTH)) dut (
    .clk            (clk),
    .reset          (reset),
    .sample_valid   (sample_valid),
    .sample_string  (sample_string),
    .sample_value   (sample_value),
    .thr_on         (thr_on),
    .thr_off        (thr_off),
    .evt_valid      (evt_valid),
    .evt_ready      (evt_ready),
    .evt_data       (evt_data),
    .string_on      (string_on),
    .overflow       (overflow),
    .clear_overflow (clear_overflow)
  );

  int         n_checks = 0;
  int         n_pass   = 0;
  logic [7:0] m_on;
  int         m_streak [8];
  logic [7:0] exp_q [$];
  logic       m_ovf;
  logic       m_vis;
  logic       did_pop;
  logic [7:0] pop_obs, pop_exp;

  task automatic model_reset();
    m_on  = '0;
    m_ovf = 1'b0;
    m_vis = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 8; i++) m_streak[i] = 0;
  endtask

  // Model: a string flips after DEB consecutive samples qualifying for the opposite state;
  // an event becomes visible the cycle after it is queued; the queue holds at most DEPTH events.
  task automatic tick(input logic v, input logic [2:0] s, input logic [7:0] val,
                      input logic rdy, input logic clr);
    logic [7:0] eff;
    logic       qual, full_now, drop;
    int         sz;
    sample_valid   = v;
    sample_string  = s;
    sample_value   = val;
    evt_ready      = rdy;
    clear_overflow = clr;
    did_pop  = (evt_valid === 1'b1) && rdy;
    pop_obs  = evt_data[7:0];
    sz       = exp_q.size();
    full_now = (sz >= DEPTH) && !did_pop;
    drop     = 1'b0;
    pop_exp  = 'x;
    if (did_pop && sz > 0) pop_exp = exp_q.pop_front();
    m_vis = (exp_q.size() > 0);
    if (v) begin
      eff  = (thr_off > thr_on) ? thr_on : thr_off;
      qual = m_on[s] ? (val < eff) : (val >= thr_on);
      if (!qual) m_streak[s] = 0;
      else begin
        m_streak[s]++;
        if (m_streak[s] == DEB) begin
          m_streak[s] = 0;
          m_on[s]     = ~m_on[s];
          if (full_now) drop = 1'b1;
          else exp_q.push_back({m_on[s], 4'b0000, s});
        end
      end
    end
    if (clr) m_ovf = 1'b0;
    else if (drop) m_ovf = 1'b1;
    @(negedge clk);
    sample_valid   = 1'b0;
    clear_overflow = 1'b0;
  endtask

  task automatic make_event(input logic [2:0] s);
    logic [7:0] val;
    val = m_on[s] ? 8'h10 : 8'hF0;
    repeat (DEB) tick(1'b1, s, val, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_checks++; if (evt_valid !== 1'b0) $display("FAIL rst_valid got %b want 0", evt_valid); else n_pass++;
    n_checks++; if (evt_data !== '0) $display("FAIL rst_data got %h want 0", evt_data); else n_pass++;
    n_checks++; if (string_on !== 8'h00) $display("FAIL rst_string_on got %h want 00", string_on); else n_pass++;
    n_checks++; if (overflow !== 1'b0) $display("FAIL rst_overflow got %b want 0", overflow); else n_pass++;
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_on_event();
    tick(1'b1, 3'd2, 8'h90, 1'b0, 1'b0);
    tick(1'b1, 3'd2, 8'h90, 1'b0, 1'b0);
    n_checks++; if (string_on[2] !== 1'b0) $display("FAIL on_early got %b want 0", string_on[2]); else n_pass++;
    tick(1'b1, 3'd2, 8'h90, 1'b0, 1'b0);
    n_checks++; if (string_on[2] !== 1'b1) $display("FAIL on_state got %b want 1", string_on[2]); else n_pass++;
    n_checks++; if (evt_valid !== 1'b0) $display("FAIL on_latency got %b want 0", evt_valid); else n_pass++;
    tick(1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
    n_checks++; if (evt_valid !== 1'b1) $display("FAIL on_valid got %b want 1", evt_valid); else n_pass++;
    n_checks++; if (evt_data[7:0] !== 8'h82) $display("FAIL on_data got %h want 82", evt_data[7:0]); else n_pass++;
    tick(1'b0, 3'd0, 8'h00, 1'b1, 1'b0);
    n_checks++; if (!(did_pop && pop_obs === 8'h82)) $display("FAIL on_pop got pop=%b data=%h want pop=1 data=82", did_pop, pop_obs); else n_pass++;
    n_checks++; if (evt_valid !== 1'b0) $display("FAIL on_drained got %b want 0", evt_valid); else n_pass++;
  endtask

  task automatic test_off_event();
    repeat (3) tick(1'b1, 3'd2, 8'h30, 1'b0, 1'b0);
    n_checks++; if (string_on[2] !== 1'b0) $display("FAIL off_state got %b want 0", string_on[2]); else n_pass++;
    tick(1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
    n_checks++; if (evt_valid !== 1'b1 || evt_data[7:0] !== 8'h02) $display("FAIL off_data got v=%b d=%h want v=1 d=02", evt_valid, evt_data[7:0]); else n_pass++;
    tick(1'b0, 3'd0, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic test_band();
    logic [7:0] seq [5];
    seq = '{8'h90, 8'h90, 8'h60, 8'h90, 8'h90};
    for (int i = 0; i < 5; i++) tick(1'b1, 3'd2, seq[i], 1'b0, 1'b0);
    tick(1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
    n_checks++; if (evt_valid !== 1'b0) $display("FAIL band_noevt got %b want 0", evt_valid); else n_pass++;
    n_checks++; if (string_on[2] !== 1'b0) $display("FAIL band_state got %b want 0", string_on[2]); else n_pass++;
    tick(1'b1, 3'd2, 8'h90, 1'b0, 1'b0);
    n_checks++; if (string_on[2] !== 1'b1) $display("FAIL band_on got %b want 1", string_on[2]); else n_pass++;
    tick(1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
    n_checks++; if (evt_data[7:0] !== 8'h82) $display("FAIL band_data got %h want 82", evt_data[7:0]); else n_pass++;
    tick(1'b0, 3'd0, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic test_overflow();
    logic [7:0] want;
    for (int i = 0; i < 9; i++) make_event(3'(i % 2));
    tick(1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
    n_checks++; if (overflow !== 1'b1) $display("FAIL ovf_set got %b want 1", overflow); else n_pass++;
    n_checks++; if (string_on[1:0] !== 2'b01) $display("FAIL ovf_state got %b want 01", string_on[1:0]); else n_pass++;
    for (int i = 0; i < 8; i++) begin
      want = {((i / 2) % 2 == 0), 4'b0000, 3'(i % 2)};
      tick(1'b0, 3'd0, 8'h00, 1'b1, 1'b0);
      n_checks++; if (!(did_pop && pop_obs === want)) $display("FAIL ovf_order[%0d] got pop=%b data=%h want %h", i, did_pop, pop_obs, want); else n_pass++;
    end
    n_checks++; if (evt_valid !== 1'b0) $display("FAIL ovf_empty got %b want 0", evt_valid); else n_pass++;
    n_checks++; if (overflow !== 1'b1) $display("FAIL ovf_sticky got %b want 1", overflow); else n_pass++;
    tick(1'b0, 3'd0, 8'h00, 1'b0, 1'b1);
    n_checks++; if (overflow !== 1'b0) $display("FAIL ovf_clear got %b want 0", overflow); else n_pass++;
  endtask

  task automatic test_full_pop();
    int   n_pops;
    logic [7:0] val;
    for (int i = 0; i < 8; i++) make_event(3'(4 + i % 2));
    val = m_on[6] ? 8'h10 : 8'hF0;
    tick(1'b1, 3'd6, val, 1'b0, 1'b0);
    tick(1'b1, 3'd6, val, 1'b0, 1'b0);
    tick(1'b1, 3'd6, val, 1'b1, 1'b0);
    tick(1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
    n_checks++; if (overflow !== 1'b0) $display("FAIL fullpop_ovf got %b want 0", overflow); else n_pass++;
    n_pops = 0;
    for (int k = 0; k < 20 && evt_valid === 1'b1; k++) begin
      tick(1'b0, 3'd0, 8'h00, 1'b1, 1'b0);
      n_pops++;
      n_checks++; if (pop_obs !== pop_exp) $display("FAIL fullpop_data[%0d] got %h want %h", k, pop_obs, pop_exp); else n_pass++;
    end
    n_checks++; if (n_pops != 8) $display("FAIL fullpop_occ got %0d want 8", n_pops); else n_pass++;
  endtask

  task automatic test_random();
    logic [7:0] on_tab  [3];
    logic [7:0] off_tab [3];
    int         rdy_pct [3];
    logic [7:0] eff, val;
    logic       v, r, c;
    logic [2:0] s;
    on_tab  = '{8'h80, 8'h50, 8'h20};
    off_tab = '{8'h40, 8'h90, 8'h20};
    rdy_pct = '{75, 15, 50};
    for (int cfg = 0; cfg < 3; cfg++) begin
      thr_on  = on_tab[cfg];
      thr_off = off_tab[cfg];
      eff     = (thr_off > thr_on) ? thr_on : thr_off;
      for (int n = 0; n < 600; n++) begin
        v = ($urandom_range(0, 9) < 7);
        s = 3'($urandom_range(0, 3));
        case ($urandom_range(0, 4))
          0:       val = 8'($urandom);
          1:       val = thr_on;
          2:       val = thr_on - 8'd1;
          3:       val = eff;
          default: val = eff - 8'd1;
        endcase
        r = ($urandom_range(0, 99) < rdy_pct[cfg]);
        c = ($urandom_range(0, 49) == 0);
        tick(v, s, val, r, c);
        n_checks++; if (string_on !== m_on) $display("FAIL rnd_string_on got %h want %h", string_on, m_on); else n_pass++;
        n_checks++; if (overflow !== m_ovf) $display("FAIL rnd_overflow got %b want %b", overflow, m_ovf); else n_pass++;
        n_checks++; if (evt_valid !== m_vis) $display("FAIL rnd_evt_valid got %b want %b", evt_valid, m_vis); else n_pass++;
        if (did_pop) begin
          n_checks++; if (pop_obs !== pop_exp) $display("FAIL rnd_evt_data got %h want %h", pop_obs, pop_exp); else n_pass++;
        end
      end
    end
    thr_on  = 8'h80;
    thr_off = 8'h40;
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 20 && evt_valid === 1'b1; k++) tick(1'b0, 3'd0, 8'h00, 1'b1, 1'b0);
    n_checks++; if (evt_valid !== 1'b0) $display("FAIL mid_drain got %b want 0", evt_valid); else n_pass++;
    tick(1'b0, 3'd0, 8'h00, 1'b0, 1'b1);
    if (m_on[5]) begin
      make_event(3'd5);
      make_event(3'd6);
    end else begin
      make_event(3'd6);
      make_event(3'd7);
    end
    make_event(3'd5);
    tick(1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
    n_checks++; if (string_on[5] !== 1'b1) $display("FAIL mid_pre_on got %b want 1", string_on[5]); else n_pass++;
    n_checks++; if (evt_valid !== 1'b1) $display("FAIL mid_pre_valid got %b want 1", evt_valid); else n_pass++;
    #2 reset = 1'b0;
    #1;
    n_checks++; if (evt_valid !== 1'b0) $display("FAIL mid_rst_valid got %b want 0", evt_valid); else n_pass++;
    n_checks++; if (string_on !== 8'h00) $display("FAIL mid_rst_string_on got %h want 00", string_on); else n_pass++;
    n_checks++; if (overflow !== 1'b0) $display("FAIL mid_rst_overflow got %b want 0", overflow); else n_pass++;
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    tick(1'b0, 3'd0, 8'h00, 1'b1, 1'b0);
    tick(1'b0, 3'd0, 8'h00, 1'b1, 1'b0);
    n_checks++; if (evt_valid !== 1'b0) $display("FAIL mid_lost got %b want 0", evt_valid); else n_pass++;
  endtask

  initial begin
    reset          = 1'b1;
    sample_valid   = 1'b0;
    sample_string  = '0;
    sample_value   = '0;
    thr_on         = 8'h80;
    thr_off        = 8'h40;
    evt_ready      = 1'b0;
    clear_overflow = 1'b0;
    model_reset();
    #2 reset = 1'b0;
    test_reset();
    test_on_event();
    test_off_event();
    test_band();
    test_overflow();
    test_full_pop();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
